// File: rtl/mul_pkg.sv
// Shared types, sizing constants and carry-lookahead helpers for the sequential multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int unsigned MUL_W    = 32;
    localparam int unsigned MUL_ITER = 32;
    localparam int unsigned MUL_LAT  = 34;

    // Internal carries c1..c3 of a 4-wide lookahead group; c4 comes from la4_gen at the next level.
    function automatic logic [2:0] la4_carry(input logic [2:0] g, input logic [2:0] p, input logic ci);
        logic [2:0] c;
        c[0] = g[0] | (p[0] & ci);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    function automatic logic la4_gen(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/cla_32.sv
// 32-bit carry-lookahead adder: eight 4-bit blocks, two 16-bit super-groups, top-level carry.
module cla_32
    import mul_pkg::*;
(
    input  logic [MUL_W-1:0] a,
    input  logic [MUL_W-1:0] b,
    input  logic             c_in,
    output logic [MUL_W-1:0] s,
    output logic             c_out
);

    localparam int unsigned NBLK = MUL_W / 4;
    localparam int unsigned NSUP = NBLK / 4;

    logic [MUL_W-1:0] g;
    logic [MUL_W-1:0] p;
    logic [MUL_W-1:0] ci_bit;
    logic [NBLK-1:0]  blk_g;
    logic [NBLK-1:0]  blk_p;
    logic [NBLK-1:0]  ci_blk;
    logic [NSUP-1:0]  sup_g;
    logic [NSUP-1:0]  sup_p;
    logic [NSUP-1:0]  ci_sup;

    assign g = a & b;
    assign p = a ^ b;

    // Block-level generate/propagate and per-bit carries from each block's carry-in.
    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        assign blk_g[i]              = la4_gen(g[4*i +: 4], p[4*i +: 4]);
        assign blk_p[i]              = &p[4*i +: 4];
        assign ci_bit[4*i]           = ci_blk[i];
        assign ci_bit[4*i + 1 +: 3]  = la4_carry(g[4*i +: 3], p[4*i +: 3], ci_blk[i]);
    end

    for (genvar j = 0; j < NSUP; j++) begin : g_sup
        assign sup_g[j]              = la4_gen(blk_g[4*j +: 4], blk_p[4*j +: 4]);
        assign sup_p[j]              = &blk_p[4*j +: 4];
        assign ci_blk[4*j]           = ci_sup[j];
        assign ci_blk[4*j + 1 +: 3]  = la4_carry(blk_g[4*j +: 3], blk_p[4*j +: 3], ci_sup[j]);
    end

    assign ci_sup[0] = c_in;
    assign ci_sup[1] = sup_g[0] | (sup_p[0] & c_in);
    assign c_out     = sup_g[1] | (sup_p[1] & sup_g[0]) | (sup_p[1] & sup_p[0] & c_in);

    assign s = p ^ ci_bit;

endmodule

// File: rtl/mul_seq_32.sv
// Radix-2 shift-add 32x32->64 multiplier with sign/magnitude handling and fixed 34-cycle latency.
module mul_seq_32
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_W
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(MUL_ITER);

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] lo_sh_q, lo_sh_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_q, neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH-1:0] sum_c;
    logic             carry_c;
    logic [WIDTH:0]   step_c;
    logic [PW-1:0]    prod_c;
    logic [PW-1:0]    res_c;

    cla_32 u_cla (
        .a     (acc_q[WIDTH-1:0]),
        .b     (mcand_q),
        .c_in  (1'b0),
        .s     (sum_c),
        .c_out (carry_c)
    );

    // Operand magnitudes, per-iteration partial sum and the final sign-corrected product.
    always_comb begin
        a_mag_c = (is_signed && a[WIDTH-1]) ? WIDTH'(~a + WIDTH'(1)) : a;
        b_mag_c = (is_signed && b[WIDTH-1]) ? WIDTH'(~b + WIDTH'(1)) : b;
        step_c  = lo_sh_q[0] ? {carry_c, sum_c} : acc_q;
        prod_c  = {acc_q[WIDTH-1:0], lo_sh_q};
        res_c   = neg_q ? PW'(~prod_c + PW'(1)) : prod_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (count_q == CW'(MUL_ITER - 1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        acc_d   = acc_q;
        lo_sh_d = lo_sh_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    lo_sh_d = a_mag_c;
                    mcand_d = b_mag_c;
                    neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            CALC: begin
                // Shift {carry,sum,lo_sh} right by one; the dropped lo_sh bit was just consumed.
                acc_d   = {1'b0, step_c[WIDTH:1]};
                lo_sh_d = {step_c[0], lo_sh_q[WIDTH-1:1]};
                count_d = count_q + CW'(1);
            end
            FIX: begin
                {hi_d, lo_d} = res_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            acc_q   <= '0;
            lo_sh_q <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            acc_q   <= acc_d;
            lo_sh_q <= lo_sh_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_seq_32.sv
// Directed and random checks of mul_seq_32 against a behavioural product model via a scoreboard queue.
module tb_mul_seq_32;
    import mul_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [63:0] exp_q[$];
    int          checks;
    int          errors;
    int          done_cnt;

    mul_seq_32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return 64'({32'b0, x}) * 64'({32'b0, y});
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Issue one operation, check latency and handshake, and pop the expected product on done.
    task automatic do_op(input string tag, input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                         input logic hold);
        int          cyc;
        logic [63:0] want;
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        a         = av;
        b         = bv;
        exp_q.push_back(model(sgn, av, bv));
        @(posedge clk);
        #1;
        chk({tag, "_busy_start"}, 64'(busy), 64'(1));
        if (hold) begin
            a = 32'd2;
            b = 32'd3;
        end else begin
            start = 1'b0;
        end
        cyc = 0;
        while (cyc < MUL_LAT + 6) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done === 1'b1) break;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(MUL_LAT - 1));
        chk({tag, "_busy_done"}, 64'(busy), 64'(1));
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 64'(0), 64'(1));
        end else begin
            want = exp_q.pop_front();
            chk({tag, "_hi"}, 64'(hi), 64'(want[63:32]));
            chk({tag, "_lo"}, 64'(lo), 64'(want[31:0]));
        end
        @(posedge clk);
        #1;
        chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
        chk({tag, "_idle_done"}, 64'(done), 64'(0));
    endtask

    initial begin
        int          base;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] held;
        checks    = 0;
        errors    = 0;
        done_cnt  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_hi", 64'(hi), 64'(0));
        chk("reset_lo", 64'(lo), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        do_op("multu_ff_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_ff_ff_model", model(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        do_op("mult_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op("mult_m1_m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op("mult_m3_5", 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0);
        do_op("multu_m3_5", 1'b0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        do_op("mult_zero", 1'b1, 32'd0, 32'h8000_0000, 1'b0);

        // Outputs hold across idle cycles.
        held = {hi, lo};
        repeat (5) @(posedge clk);
        #1;
        chk("hold_idle", {hi, lo}, 64'h0);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_op("rand", 1'(i % 2), ra, rb, 1'b0);
        end
        held = {hi, lo};
        repeat (4) @(posedge clk);
        #1;
        chk("hold_rand", {hi, lo}, model(1'b1, ra, rb));

        // start held high throughout the operation and into DONE.
        base = done_cnt;
        do_op("hold_7x9", 1'b0, 32'd7, 32'd9, 1'b1);
        chk("hold_one_done", 64'(done_cnt - base), 64'(1));
        do_op("next_2x3", 1'b0, 32'd2, 32'd3, 1'b0);
        chk("two_dones", 64'(done_cnt - base), 64'(2));

        // Reset at iteration 10 aborts the operation.
        base = done_cnt;
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        a         = 32'h1234;
        b         = 32'h5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_hi", 64'(hi), 64'(0));
        chk("abort_lo", 64'(lo), 64'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt - base), 64'(0));
        do_op("after_abort", 1'b0, 32'h1234, 32'h5678, 1'b0);
        chk("after_abort_lo", 64'(lo), 64'h0626_0060);

        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
